// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word, RAM status and arbiter state types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IGNT  = 3'd1,
        DRGNT = 3'd2,
        DWGNT = 3'd3,
        RETRY = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache and RAM side signals of the memory arbiter
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one RAM port between icache and dcache
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned RETRY_GAP    = 1
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
    localparam logic [1:0] GAP_M1 = 2'(RETRY_GAP - 1);

    arb_state_t state_q, state_d;
    arb_state_t ret_q, ret_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] retry_q, retry_d;
    logic       ramren_q, ramren_d;
    logic       ramwen_q, ramwen_d;
    word_t      ramaddr_q, ramaddr_d;
    word_t      ramstore_q, ramstore_d;

    arb_state_t owner;
    logic       owner_req;
    logic [3:0] cnt_inc;

    // During RETRY the owner is the grant we will return to.
    assign owner   = (state_q == RETRY) ? ret_q : state_q;
    assign cnt_inc = (cnt_q == LIMIT) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        owner_req = 1'b0;
        case (owner)
            IGNT:    owner_req = bus.iREN;
            DRGNT:   owner_req = bus.dREN;
            DWGNT:   owner_req = bus.dWEN;
            default: owner_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        ramren_d   = ramren_q;
        ramwen_d   = ramwen_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        case (state_q)
            IDLE: begin
                if (!bus.iREN) cnt_d = '0;
                if (bus.iREN && cnt_q == LIMIT) begin
                    state_d    = IGNT;
                    cnt_d      = '0;
                    ramren_d   = 1'b1;
                    ramaddr_d  = bus.iaddr;
                    ramstore_d = '0;
                end else if (bus.dWEN) begin
                    state_d    = DWGNT;
                    ramwen_d   = 1'b1;
                    ramaddr_d  = bus.daddr;
                    ramstore_d = bus.dstore;
                    if (bus.iREN) cnt_d = cnt_inc;
                end else if (bus.dREN) begin
                    state_d    = DRGNT;
                    ramren_d   = 1'b1;
                    ramaddr_d  = bus.daddr;
                    ramstore_d = bus.dstore;
                    if (bus.iREN) cnt_d = cnt_inc;
                end else if (bus.iREN) begin
                    state_d    = IGNT;
                    cnt_d      = '0;
                    ramren_d   = 1'b1;
                    ramaddr_d  = bus.iaddr;
                    ramstore_d = '0;
                end
            end
            IGNT, DRGNT, DWGNT: begin
                if (bus.ramstate == ACCESS) begin
                    state_d  = IDLE;
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                end else if (bus.ramstate == ERROR) begin
                    state_d  = RETRY;
                    ret_d    = state_q;
                    retry_d  = GAP_M1;
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                end else if (!owner_req) begin
                    state_d  = IDLE;
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                end
            end
            RETRY: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (retry_q == 2'd0) begin
                    state_d  = ret_q;
                    ramren_d = (ret_q != DWGNT);
                    ramwen_d = (ret_q == DWGNT);
                end else begin
                    retry_d = retry_q - 2'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                ramren_d = 1'b0;
                ramwen_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            ret_q      <= IDLE;
            cnt_q      <= '0;
            retry_q    <= '0;
            ramren_q   <= 1'b0;
            ramwen_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            ramren_q   <= ramren_d;
            ramwen_q   <= ramwen_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
        end
    end

    assign bus.ramREN   = ramren_q;
    assign bus.ramWEN   = ramwen_q;
    assign bus.ramaddr  = ramaddr_q;
    assign bus.ramstore = ramstore_q;
    assign bus.iwait    = !(state_q == IGNT && bus.ramstate == ACCESS);
    assign bus.dwait    = !((state_q == DRGNT || state_q == DWGNT) && bus.ramstate == ACCESS);
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;

endmodule
